// File: rtl/tile_sequencer.sv
// Piano-tile note source: beat timing, LFSR tile generation,
// playfield scrolling, game FSM and saturating score.
module tile_sequencer #(
   parameter int         BEAT_DIV = 12500000,
   parameter int         DEPTH    = 8,
   parameter int         SONG_LEN = 64,
   parameter logic [7:0] SEED     = 8'hA5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         score_in,
   output logic               beat,
   output logic [2:0]         data,
   output logic [3*DEPTH-1:0] rows,
   output logic [7:0]         total_score,
   output logic               playing,
   output logic               game_over
);

   localparam int CW = $clog2(BEAT_DIV);
   localparam int DW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CMAX  = CW'(BEAT_DIV - 1);
   localparam logic [DW-1:0] DLAST = DW'(DEPTH - 1);
   localparam logic [7:0]    SLAST = 8'(SONG_LEN - 1);

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      DRAIN,
      OVER
   } state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [DW-1:0]      drained;
   logic [7:0]         issued;
   logic [7:0]         lfsr;
   logic [7:0]         score;
   logic [3*DEPTH-1:0] field;
   logic [2:0]         tile;
   logic [8:0]         sum;
   logic [7:0]         sat;
   logic               active;
   logic               lfsr_fb;

   // Beat strobe is the last count of each beat while a game runs
   assign active      = (state == PLAY) || (state == DRAIN);
   assign beat        = active && (cnt == CMAX);
   assign rows        = field;
   assign data        = field[2:0];
   assign total_score = score;
   assign playing     = active;
   assign game_over   = (state == OVER);
   assign lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   // Map the low LFSR bits onto a lane (or a rest)
   always_comb begin
      tile = 3'b000;
      unique case (lfsr[1:0])
         2'd0:    tile = 3'b100;
         2'd1:    tile = 3'b010;
         2'd2:    tile = 3'b001;
         default: tile = 3'b000;
      endcase
   end

   // Saturating add of the checker's per-beat hits
   always_comb begin
      sum = {1'b0, score} + {7'b0, score_in};
      sat = sum[8] ? 8'hFF : sum[7:0];
   end

   // Game FSM with beat counter, scroll, LFSR and score state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         drained <= '0;
         issued  <= '0;
         lfsr    <= SEED;
         score   <= '0;
         field   <= '0;
      end else begin
         unique case (state)
            IDLE, OVER: begin
               if (start) begin
                  state   <= PLAY;
                  cnt     <= '0;
                  drained <= '0;
                  issued  <= '0;
                  lfsr    <= SEED;
                  score   <= '0;
                  field   <= '0;
               end
            end
            PLAY: begin
               cnt <= beat ? '0 : cnt + 1'b1;
               if (beat) begin
                  field  <= {tile, field[3*DEPTH-1:3]};
                  lfsr   <= {lfsr[6:0], lfsr_fb};
                  score  <= sat;
                  issued <= issued + 8'd1;
                  if (issued == SLAST) begin
                     state   <= DRAIN;
                     drained <= '0;
                  end
               end
            end
            DRAIN: begin
               cnt <= beat ? '0 : cnt + 1'b1;
               if (beat) begin
                  field   <= {3'b000, field[3*DEPTH-1:3]};
                  score   <= sat;
                  drained <= drained + 1'b1;
                  if (drained == DLAST) begin
                     state <= OVER;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tile_sequencer.sv
// Bench for tile_sequencer: directed table, corner sequences and a
// random run against a beat-count based reference model.
module tb_tile_sequencer;

   logic        clk;
   logic        rst;
   logic        start_a, start_b;
   logic [1:0]  si_a, si_b;
   logic        beat_a, beat_b;
   logic [2:0]  data_a, data_b;
   logic [11:0] rows_a;
   logic [23:0] rows_b;
   logic [7:0]  score_a, score_b;
   logic        playing_a, playing_b;
   logic        over_a, over_b;

   int checks = 0;
   int errors = 0;

   tile_sequencer #(
      .BEAT_DIV(4), .DEPTH(4), .SONG_LEN(6), .SEED(8'hA5)
   ) u_a (
      .clk(clk), .rst(rst), .start(start_a), .score_in(si_a),
      .beat(beat_a), .data(data_a), .rows(rows_a),
      .total_score(score_a), .playing(playing_a), .game_over(over_a)
   );

   tile_sequencer #(
      .BEAT_DIV(3), .DEPTH(8), .SONG_LEN(100), .SEED(8'hA5)
   ) u_b (
      .clk(clk), .rst(rst), .start(start_b), .score_in(si_b),
      .beat(beat_b), .data(data_b), .rows(rows_b),
      .total_score(score_b), .playing(playing_b), .game_over(over_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: tiles come from the LFSR sequence; rows are derived
   // from the number of completed beats since the game started.
   logic [2:0] tiles [256];
   int bd [2];
   int dp [2];
   int sln [2];
   int m_ph [2];
   int m_c [2];
   int m_sc [2];

   function automatic logic m_beat(input int u);
      return (m_ph[u] == 1) && (m_c[u] % bd[u] == bd[u] - 1);
   endfunction

   function automatic logic [23:0] m_rows(input int u);
      logic [23:0] r;
      int nb;
      int idx;
      r = '0;
      nb = m_c[u] / bd[u];
      for (int i = 0; i < dp[u]; i++) begin
         idx = nb - dp[u] + i;
         if (idx >= 0 && idx < sln[u]) r[3*i +: 3] = tiles[idx];
      end
      return r;
   endfunction

   task automatic step(input int u, input logic st, input logic [1:0] si);
      int s;
      if (!rst) begin
         m_ph[u] = 0;
         m_c[u] = 0;
         m_sc[u] = 0;
      end else if (m_ph[u] != 1) begin
         if (st) begin
            m_ph[u] = 1;
            m_c[u] = 0;
            m_sc[u] = 0;
         end
      end else begin
         if (m_beat(u)) begin
            s = m_sc[u] + int'(si);
            m_sc[u] = (s > 255) ? 255 : s;
         end
         m_c[u]++;
         if (m_c[u] / bd[u] == sln[u] + dp[u]) m_ph[u] = 2;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cmp_all();
      logic [23:0] ra, rb;
      ra = m_rows(0);
      rb = m_rows(1);
      chk("a_beat", 32'(beat_a), 32'(m_beat(0)));
      chk("a_rows", 32'(rows_a), 32'(ra[11:0]));
      chk("a_data", 32'(data_a), 32'(ra[2:0]));
      chk("a_score", 32'(score_a), 32'(m_sc[0]));
      chk("a_playing", 32'(playing_a), 32'(m_ph[0] == 1));
      chk("a_over", 32'(over_a), 32'(m_ph[0] == 2));
      chk("b_beat", 32'(beat_b), 32'(m_beat(1)));
      chk("b_rows", 32'(rows_b), 32'(rb));
      chk("b_data", 32'(data_b), 32'(rb[2:0]));
      chk("b_score", 32'(score_b), 32'(m_sc[1]));
      chk("b_playing", 32'(playing_b), 32'(m_ph[1] == 1));
      chk("b_over", 32'(over_b), 32'(m_ph[1] == 2));
   endtask

   task automatic cycle();
      @(posedge clk);
      step(0, start_a, si_a);
      step(1, start_b, si_b);
      #1;
      cmp_all();
   endtask

   typedef struct {
      logic        st;
      logic [1:0]  si;
      logic        bt;
      logic [11:0] rw;
      logic [7:0]  sc;
   } vec_t;

   vec_t tbl [17];

   initial begin
      int x;
      int n;
      int nbeat;
      int nplay;
      int nbb;
      logic was_beat;

      tbl[0]  = '{1'b1, 2'd2, 1'b0, 12'h000, 8'd0};
      tbl[1]  = '{1'b0, 2'd2, 1'b0, 12'h000, 8'd0};
      tbl[2]  = '{1'b1, 2'd2, 1'b0, 12'h000, 8'd0};
      tbl[3]  = '{1'b0, 2'd2, 1'b1, 12'h000, 8'd0};
      tbl[4]  = '{1'b0, 2'd1, 1'b0, 12'h400, 8'd1};
      tbl[5]  = '{1'b0, 2'd3, 1'b0, 12'h400, 8'd1};
      tbl[6]  = '{1'b1, 2'd3, 1'b0, 12'h400, 8'd1};
      tbl[7]  = '{1'b0, 2'd3, 1'b1, 12'h400, 8'd1};
      tbl[8]  = '{1'b0, 2'd1, 1'b0, 12'h280, 8'd2};
      tbl[9]  = '{1'b0, 2'd2, 1'b0, 12'h280, 8'd2};
      tbl[10] = '{1'b0, 2'd2, 1'b0, 12'h280, 8'd2};
      tbl[11] = '{1'b0, 2'd2, 1'b1, 12'h280, 8'd2};
      tbl[12] = '{1'b0, 2'd0, 1'b0, 12'h450, 8'd2};
      tbl[13] = '{1'b0, 2'd3, 1'b0, 12'h450, 8'd2};
      tbl[14] = '{1'b0, 2'd3, 1'b0, 12'h450, 8'd2};
      tbl[15] = '{1'b0, 2'd3, 1'b1, 12'h450, 8'd2};
      tbl[16] = '{1'b0, 2'd2, 1'b0, 12'h28A, 8'd4};

      bd[0] = 4;  dp[0] = 4; sln[0] = 6;
      bd[1] = 3;  dp[1] = 8; sln[1] = 100;
      x = 8'hA5;
      for (int i = 0; i < 256; i++) begin
         case (x % 4)
            0:       tiles[i] = 3'b100;
            1:       tiles[i] = 3'b010;
            2:       tiles[i] = 3'b001;
            default: tiles[i] = 3'b000;
         endcase
         x = ((x * 2) % 256) + (((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1);
      end
      for (int u = 0; u < 2; u++) begin
         m_ph[u] = 0;
         m_c[u] = 0;
         m_sc[u] = 0;
      end

      rst = 1'b0;
      start_a = 1'b0; start_b = 1'b0;
      si_a = 2'd0; si_b = 2'd0;
      repeat (2) cycle();
      rst = 1'b1;
      repeat (2) cycle();

      // Directed opening of a game on instance A
      nbeat = 0;
      nplay = 0;
      for (int i = 0; i < 17; i++) begin
         start_a = tbl[i].st;
         si_a = tbl[i].si;
         cycle();
         chk("tbl_beat", 32'(beat_a), 32'(tbl[i].bt));
         chk("tbl_rows", 32'(rows_a), 32'(tbl[i].rw));
         chk("tbl_score", 32'(score_a), 32'(tbl[i].sc));
         chk("tbl_playing", 32'(playing_a), 32'd1);
         if (beat_a) nbeat++;
         if (playing_a) nplay++;
      end
      chk("tbl_data", 32'(data_a), 32'(3'b010));

      // Finish the game: 6 play beats plus 4 drain beats
      start_a = 1'b0;
      n = 0;
      while (!over_a && n < 200) begin
         si_a = 2'($urandom_range(0, 3));
         cycle();
         if (beat_a) nbeat++;
         if (playing_a) nplay++;
         n++;
      end
      chk("a_game_done", 32'(over_a), 32'd1);
      chk("a_game_beats", 32'(nbeat), 32'd10);
      chk("a_play_cycles", 32'(nplay), 32'd40);
      chk("a_final_rows", 32'(rows_a), 32'd0);
      repeat (3) cycle();

      // Restart from OVER; start held high is ignored while playing
      start_a = 1'b1;
      cycle();
      chk("a_restart_play", 32'(playing_a), 32'd1);
      chk("a_restart_score", 32'(score_a), 32'd0);
      n = 0;
      while (!beat_a && n < 10) begin
         cycle();
         n++;
      end
      chk("a_restart_beat_seen", 32'(beat_a), 32'd1);
      cycle();
      chk("a_restart_tile", 32'(rows_a[11:9]), 32'(3'b010));
      start_a = 1'b0;
      repeat (10) cycle();
      chk("a_rows_busy", 32'(rows_a != 12'h000), 32'd1);

      // Asynchronous reset mid-game
      #2;
      rst = 1'b0;
      #1;
      chk("rst_rows", 32'(rows_a), 32'd0);
      chk("rst_score", 32'(score_a), 32'd0);
      chk("rst_beat", 32'(beat_a), 32'd0);
      chk("rst_playing", 32'(playing_a), 32'd0);
      start_a = 1'b1;
      repeat (2) cycle();
      start_a = 1'b0;
      rst = 1'b1;
      repeat (12) cycle();

      // Saturation on instance B: 3 per beat, 2 between beats
      start_b = 1'b1;
      cycle();
      start_b = 1'b0;
      nbb = 0;
      n = 0;
      while (!over_b && n < 1000) begin
         was_beat = m_beat(1);
         si_b = was_beat ? 2'd3 : 2'd2;
         cycle();
         if (was_beat) begin
            nbb++;
            chk("b_sat", 32'(score_b), 32'((3 * nbb > 255) ? 255 : 3 * nbb));
         end
         n++;
      end
      chk("b_game_done", 32'(over_b), 32'd1);
      chk("b_game_beats", 32'(nbb), 32'd108);
      chk("b_final_score", 32'(score_b), 32'd255);

      // Random stimulus on both instances
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 599) != 0);
         start_a = ($urandom_range(0, 29) == 0);
         start_b = ($urandom_range(0, 59) == 0);
         si_a = 2'($urandom_range(0, 3));
         si_b = 2'($urandom_range(0, 3));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
